// File: rtl/write_back_stack_if.sv
// Write-back stage bus bundle.
// Groups the execute-result handshake, the random-access state memory write
// port and the sequential stack push port.
//   slave  : the write_back_stack stage (consumes results, drives both write ports)
//   master : the execute stage / memories side
interface write_back_stack_if #(
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 5,
    parameter int FIELD_W = 8
);
    localparam int STATE_W = POS_W + ADDR_W + 1;

    // execute-result handshake
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    current_addr_i;
    logic [2:0]           over_i;
    logic                 en_new_position_i;
    logic [POS_W-1:0]     new_position_i;
    logic                 new_call_i;
    logic [FIELD_W-1:0]   i_new_i;
    logic [FIELD_W-1:0]   z_new_i;
    logic [FIELD_W-1:0]   k_new_i;
    logic [FIELD_W-1:0]   l_new_i;

    // random-access state write port
    logic                 ran_we_state;
    logic [2:0]           ran_w_be_state;
    logic [ADDR_W-1:0]    ran_w_addr_state;
    logic [STATE_W-1:0]   ran_w_data_state;

    // sequential stack push port
    logic                 seq_we;
    logic                 seq_ready;
    logic [ADDR_W-1:0]    seq_w_addr;
    logic [STATE_W-1:0]   seq_w_data_state;
    logic [4*FIELD_W-1:0] seq_w_data_InexRecur;

    modport slave (
        input  in_valid, current_addr_i, over_i, en_new_position_i, new_position_i,
               new_call_i, i_new_i, z_new_i, k_new_i, l_new_i, seq_ready,
        output in_ready, ran_we_state, ran_w_be_state, ran_w_addr_state, ran_w_data_state,
               seq_we, seq_w_addr, seq_w_data_state, seq_w_data_InexRecur
    );

    modport master (
        output in_valid, current_addr_i, over_i, en_new_position_i, new_position_i,
               new_call_i, i_new_i, z_new_i, k_new_i, l_new_i, seq_ready,
        input  in_ready, ran_we_state, ran_w_be_state, ran_w_addr_state, ran_w_data_state,
               seq_we, seq_w_addr, seq_w_data_state, seq_w_data_InexRecur
    );
endinterface

// File: rtl/write_back_stack.sv
// Registered recursion write-back stage.
// Takes one execute result per handshake, commits position/done updates to the
// random-access state memory with per-field byte enables, and pushes new calls
// onto the sequential stack at an internally kept stack pointer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sp_clear    : synchronous stack-pointer clear, cancels a pending push
//   bus         : result handshake + random write port + stack push port
//   seq_ptr     : current stack pointer (next free entry)
//   overflow    : sticky, a push was attempted with a full stack
//   term_cause  : last termination cause (0 none, 1 over[0], 2 over[1], 3 over[2])
module write_back_stack #(
    parameter int ADDR_W  = 12,
    parameter int POS_W   = 5,
    parameter int FIELD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sp_clear,
    write_back_stack_if.slave bus,
    output logic [ADDR_W-1:0] seq_ptr,
    output logic              overflow,
    output logic [1:0]        term_cause
);
    localparam int STATE_W = POS_W + ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic              accept;
    logic              any_over;
    logic              ran_wr;
    logic              push_done;
    logic              push_req;
    logic              push_new;
    logic [ADDR_W-1:0] ptr_base;

    // A held push blocks new results until the stack port takes it.
    assign bus.in_ready = !bus.seq_we || bus.seq_ready;

    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        any_over  = |bus.over_i;
        ran_wr    = accept && (any_over || bus.en_new_position_i);
        push_done = bus.seq_we && bus.seq_ready && !sp_clear;
        // Pointer after this cycle's clear/completion; a new push lands here.
        if (sp_clear)
            ptr_base = '0;
        else if (push_done)
            ptr_base = seq_ptr + 1'b1;
        else
            ptr_base = seq_ptr;
        push_req = accept && bus.new_call_i;
        push_new = push_req && (ptr_base != PTR_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ran_we_state         <= 1'b0;
            bus.ran_w_be_state       <= '0;
            bus.ran_w_addr_state     <= '0;
            bus.ran_w_data_state     <= '0;
            bus.seq_we               <= 1'b0;
            bus.seq_w_addr           <= '0;
            bus.seq_w_data_state     <= '0;
            bus.seq_w_data_InexRecur <= '0;
            seq_ptr                  <= '0;
            overflow                 <= 1'b0;
            term_cause               <= 2'd0;
        end else begin
            bus.ran_we_state <= ran_wr;
            if (ran_wr) begin
                bus.ran_w_be_state   <= {bus.en_new_position_i, 1'b0, any_over};
                bus.ran_w_addr_state <= bus.current_addr_i;
                bus.ran_w_data_state <= {(bus.en_new_position_i ? bus.new_position_i : {POS_W{1'b0}}),
                                         {ADDR_W{1'b0}}, any_over};
            end else begin
                bus.ran_w_be_state   <= '0;
                bus.ran_w_addr_state <= '0;
                bus.ran_w_data_state <= '0;
            end

            if (accept && any_over) begin
                if (bus.over_i[0])
                    term_cause <= 2'd1;
                else if (bus.over_i[1])
                    term_cause <= 2'd2;
                else
                    term_cause <= 2'd3;
            end

            seq_ptr <= ptr_base;

            if (push_new) begin
                bus.seq_we               <= 1'b1;
                bus.seq_w_addr           <= ptr_base;
                bus.seq_w_data_state     <= {{POS_W{1'b0}}, bus.current_addr_i, 1'b0};
                bus.seq_w_data_InexRecur <= {bus.i_new_i, bus.z_new_i, bus.k_new_i, bus.l_new_i};
            end else if (sp_clear || push_done) begin
                bus.seq_we <= 1'b0;
            end

            if (push_req && (ptr_base == PTR_MAX))
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_write_back_stack.sv
module tb_write_back_stack;
    localparam int ADDR_W  = 12;
    localparam int POS_W   = 5;
    localparam int FIELD_W = 8;

    logic              clk;
    logic              rst_n;
    logic              sp_clear;
    logic [ADDR_W-1:0] seq_ptr;
    logic              overflow;
    logic [1:0]        term_cause;

    int checks   = 0;
    int failures = 0;

    write_back_stack_if #(.ADDR_W(ADDR_W), .POS_W(POS_W), .FIELD_W(FIELD_W)) b ();

    write_back_stack #(.ADDR_W(ADDR_W), .POS_W(POS_W), .FIELD_W(FIELD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sp_clear   (sp_clear),
        .bus        (b),
        .seq_ptr    (seq_ptr),
        .overflow   (overflow),
        .term_cause (term_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b.in_valid          = 1'b0;
        b.current_addr_i    = '0;
        b.over_i            = 3'b000;
        b.en_new_position_i = 1'b0;
        b.new_position_i    = '0;
        b.new_call_i        = 1'b0;
        b.i_new_i           = '0;
        b.z_new_i           = '0;
        b.k_new_i           = '0;
        b.l_new_i           = '0;
        sp_clear            = 1'b0;
    endtask

    task automatic drive_push(input logic [11:0] addr, input logic [31:0] izkl);
        b.in_valid       = 1'b1;
        b.new_call_i     = 1'b1;
        b.current_addr_i = addr;
        {b.i_new_i, b.z_new_i, b.k_new_i, b.l_new_i} = izkl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        b.seq_ready = 1'b0;
        step();
        step();
        checks++; if (b.ran_we_state !== 1'b0) begin failures++; $display("FAIL rst_ran_we got=%0h exp=0", b.ran_we_state); end
        checks++; if (b.seq_we !== 1'b0) begin failures++; $display("FAIL rst_seq_we got=%0h exp=0", b.seq_we); end
        checks++; if (seq_ptr !== 12'h000) begin failures++; $display("FAIL rst_seq_ptr got=%0h exp=0", seq_ptr); end
        checks++; if (overflow !== 1'b0 || term_cause !== 2'd0) begin failures++; $display("FAIL rst_flags got=%0h/%0h exp=0/0", overflow, term_cause); end
        rst_n = 1'b1;
        step();
        checks++; if (b.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", b.in_ready); end
    endtask

    task automatic test_position_update();
        b.in_valid = 1'b1; b.current_addr_i = 12'h012; b.en_new_position_i = 1'b1; b.new_position_i = 5'd5;
        step();
        clear_inputs();
        checks++; if (b.ran_we_state !== 1'b1) begin failures++; $display("FAIL pos_we got=%0h exp=1", b.ran_we_state); end
        checks++; if (b.ran_w_addr_state !== 12'h012) begin failures++; $display("FAIL pos_addr got=%0h exp=12", b.ran_w_addr_state); end
        checks++; if (b.ran_w_be_state !== 3'b100) begin failures++; $display("FAIL pos_be got=%0b exp=100", b.ran_w_be_state); end
        checks++; if (b.ran_w_data_state !== 18'h0A000) begin failures++; $display("FAIL pos_data got=%0h exp=a000", b.ran_w_data_state); end
        checks++; if (b.seq_we !== 1'b0) begin failures++; $display("FAIL pos_no_push got=%0h exp=0", b.seq_we); end
        step();
        checks++; if (b.ran_we_state !== 1'b0) begin failures++; $display("FAIL pos_pulse got=%0h exp=0", b.ran_we_state); end
    endtask

    task automatic test_merged_write();
        b.in_valid = 1'b1; b.current_addr_i = 12'h034; b.over_i = 3'b011;
        b.en_new_position_i = 1'b1; b.new_position_i = 5'd3;
        step();
        clear_inputs();
        checks++; if (b.ran_we_state !== 1'b1 || b.ran_w_addr_state !== 12'h034) begin failures++; $display("FAIL merged_we_addr got=%0h/%0h exp=1/34", b.ran_we_state, b.ran_w_addr_state); end
        checks++; if (b.ran_w_be_state !== 3'b101) begin failures++; $display("FAIL merged_be got=%0b exp=101", b.ran_w_be_state); end
        checks++; if (b.ran_w_data_state !== 18'h06001) begin failures++; $display("FAIL merged_data got=%0h exp=6001", b.ran_w_data_state); end
        checks++; if (term_cause !== 2'd1) begin failures++; $display("FAIL merged_term got=%0d exp=1", term_cause); end
    endtask

    task automatic test_term_priority();
        b.in_valid = 1'b1; b.current_addr_i = 12'h100; b.over_i = 3'b110;
        step();
        clear_inputs();
        checks++; if (term_cause !== 2'd2) begin failures++; $display("FAIL prio_110 got=%0d exp=2", term_cause); end
        checks++; if (b.ran_w_be_state !== 3'b001 || b.ran_w_data_state !== 18'h00001) begin failures++; $display("FAIL prio_done_write got=%0b/%0h exp=001/1", b.ran_w_be_state, b.ran_w_data_state); end
        b.in_valid = 1'b1; b.over_i = 3'b100;
        step();
        clear_inputs();
        checks++; if (term_cause !== 2'd3) begin failures++; $display("FAIL prio_100 got=%0d exp=3", term_cause); end
    endtask

    task automatic test_no_flags();
        b.in_valid = 1'b1; b.current_addr_i = 12'h3FF;
        checks++; if (b.in_ready !== 1'b1) begin failures++; $display("FAIL noflag_ready got=%0h exp=1", b.in_ready); end
        step();
        clear_inputs();
        checks++; if (b.ran_we_state !== 1'b0 || b.seq_we !== 1'b0) begin failures++; $display("FAIL noflag_writes got=%0h/%0h exp=0/0", b.ran_we_state, b.seq_we); end
        checks++; if (term_cause !== 2'd3) begin failures++; $display("FAIL noflag_term got=%0d exp=3", term_cause); end
    endtask

    task automatic test_push();
        b.seq_ready = 1'b1;
        drive_push(12'h007, 32'h11223344);
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h000) begin failures++; $display("FAIL push_we_addr got=%0h/%0h exp=1/0", b.seq_we, b.seq_w_addr); end
        checks++; if (b.seq_w_data_InexRecur !== 32'h11223344) begin failures++; $display("FAIL push_inex got=%0h exp=11223344", b.seq_w_data_InexRecur); end
        checks++; if (b.seq_w_data_state !== 18'h0000E) begin failures++; $display("FAIL push_state got=%0h exp=e", b.seq_w_data_state); end
        checks++; if (b.ran_we_state !== 1'b0) begin failures++; $display("FAIL push_no_ran got=%0h exp=0", b.ran_we_state); end
        step();
        checks++; if (seq_ptr !== 12'h001 || b.seq_we !== 1'b0) begin failures++; $display("FAIL push_done got=%0h/%0h exp=1/0", seq_ptr, b.seq_we); end
    endtask

    task automatic test_back_to_back();
        b.seq_ready = 1'b0;
        drive_push(12'h009, 32'hAABBCCDD);
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h001 || b.seq_w_data_state !== 18'h00012) begin failures++; $display("FAIL bp_issue got=%0h/%0h/%0h exp=1/1/12", b.seq_we, b.seq_w_addr, b.seq_w_data_state); end
        drive_push(12'h0FF, 32'h01020304);
        b.en_new_position_i = 1'b1; b.new_position_i = 5'd7;
        for (int c = 0; c < 3; c++) begin
            checks++; if (b.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%0h exp=0", c, b.in_ready); end
            step();
            checks++; if (b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h001 || b.seq_w_data_InexRecur !== 32'hAABBCCDD) begin failures++; $display("FAIL bp_hold c=%0d got=%0h/%0h/%0h exp=1/1/aabbccdd", c, b.seq_we, b.seq_w_addr, b.seq_w_data_InexRecur); end
            checks++; if (b.ran_we_state !== 1'b0 || seq_ptr !== 12'h001) begin failures++; $display("FAIL bp_not_accepted c=%0d got=%0h/%0h exp=0/1", c, b.ran_we_state, seq_ptr); end
        end
        b.seq_ready = 1'b1;
        #1;
        checks++; if (b.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", b.in_ready); end
        step();
        clear_inputs();
        checks++; if (seq_ptr !== 12'h002 || b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h002) begin failures++; $display("FAIL b2b_push got=%0h/%0h/%0h exp=2/1/2", seq_ptr, b.seq_we, b.seq_w_addr); end
        checks++; if (b.seq_w_data_InexRecur !== 32'h01020304 || b.seq_w_data_state !== 18'h001FE) begin failures++; $display("FAIL b2b_data got=%0h/%0h exp=01020304/1fe", b.seq_w_data_InexRecur, b.seq_w_data_state); end
        checks++; if (b.ran_we_state !== 1'b1 || b.ran_w_be_state !== 3'b100) begin failures++; $display("FAIL b2b_ran got=%0h/%0b exp=1/100", b.ran_we_state, b.ran_w_be_state); end
        step();
        checks++; if (seq_ptr !== 12'h003 || b.seq_we !== 1'b0) begin failures++; $display("FAIL b2b_done got=%0h/%0h exp=3/0", seq_ptr, b.seq_we); end
    endtask

    task automatic test_overflow();
        int n;
        n = 0;
        b.seq_ready = 1'b1;
        while (seq_ptr !== 12'hFFF && n < 5000) begin
            drive_push(12'h020, 32'h0);
            step();
            clear_inputs();
            step();
            n++;
        end
        checks++; if (seq_ptr !== 12'hFFF || n != 4092) begin failures++; $display("FAIL ovf_fill got=%0h pushes=%0d exp=fff pushes=4092", seq_ptr, n); end
        checks++; if (overflow !== 1'b0 || b.seq_w_addr !== 12'hFFE) begin failures++; $display("FAIL ovf_pre got=%0h/%0h exp=0/ffe", overflow, b.seq_w_addr); end
        drive_push(12'h0AB, 32'h99999999);
        b.over_i = 3'b100;
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b0 || overflow !== 1'b1 || seq_ptr !== 12'hFFF) begin failures++; $display("FAIL ovf_full got=%0h/%0h/%0h exp=0/1/fff", b.seq_we, overflow, seq_ptr); end
        checks++; if (b.ran_we_state !== 1'b1 || b.ran_w_addr_state !== 12'h0AB || b.ran_w_be_state !== 3'b001 || b.ran_w_data_state !== 18'h00001) begin failures++; $display("FAIL ovf_ran got=%0h/%0h/%0b/%0h exp=1/ab/001/1", b.ran_we_state, b.ran_w_addr_state, b.ran_w_be_state, b.ran_w_data_state); end
        step();
        checks++; if (overflow !== 1'b1 || seq_ptr !== 12'hFFF) begin failures++; $display("FAIL ovf_sticky got=%0h/%0h exp=1/fff", overflow, seq_ptr); end
    endtask

    task automatic test_sp_clear();
        b.seq_ready = 1'b0;
        drive_push(12'h005, 32'h55667788);
        sp_clear = 1'b1;
        step();
        clear_inputs();
        checks++; if (seq_ptr !== 12'h000 || b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h000) begin failures++; $display("FAIL clr_push got=%0h/%0h/%0h exp=0/1/0", seq_ptr, b.seq_we, b.seq_w_addr); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_ovf_kept got=%0h exp=1", overflow); end
        sp_clear = 1'b1;
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b0 || seq_ptr !== 12'h000) begin failures++; $display("FAIL clr_cancel got=%0h/%0h exp=0/0", b.seq_we, seq_ptr); end
    endtask

    task automatic test_reset_mid_push();
        b.seq_ready = 1'b0;
        drive_push(12'h00C, 32'hDEADBEEF);
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b1) begin failures++; $display("FAIL rmp_pending got=%0h exp=1", b.seq_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (b.seq_we !== 1'b0 || b.seq_w_data_InexRecur !== 32'h0 || b.seq_w_addr !== 12'h0) begin failures++; $display("FAIL rmp_seq got=%0h/%0h/%0h exp=0/0/0", b.seq_we, b.seq_w_data_InexRecur, b.seq_w_addr); end
        checks++; if (overflow !== 1'b0 || term_cause !== 2'd0 || seq_ptr !== 12'h0) begin failures++; $display("FAIL rmp_state got=%0h/%0h/%0h exp=0/0/0", overflow, term_cause, seq_ptr); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (b.seq_we !== 1'b0 || b.in_ready !== 1'b1) begin failures++; $display("FAIL rmp_abandoned got=%0h/%0h exp=0/1", b.seq_we, b.in_ready); end
        b.seq_ready = 1'b1;
        drive_push(12'h00D, 32'h0A0B0C0D);
        sp_clear = 1'b1;
        step();
        clear_inputs();
        checks++; if (b.seq_we !== 1'b1 || b.seq_w_addr !== 12'h000 || b.seq_w_data_state !== 18'h0001A) begin failures++; $display("FAIL rmp_clr_push got=%0h/%0h/%0h exp=1/0/1a", b.seq_we, b.seq_w_addr, b.seq_w_data_state); end
        step();
        checks++; if (seq_ptr !== 12'h001 || b.seq_we !== 1'b0) begin failures++; $display("FAIL rmp_done got=%0h/%0h exp=1/0", seq_ptr, b.seq_we); end
    endtask

    initial begin
        test_reset();
        test_position_update();
        test_merged_write();
        test_term_priority();
        test_no_flags();
        test_push();
        test_back_to_back();
        test_overflow();
        test_sp_clear();
        test_reset_mid_push();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
